spi_baud_generator: RTL and testbench

- Generates the SPI serial clock `sclk` from `PCLK` for the master-mode SPI core.
- Produces `BaudRateDivisor` for the slave-select stage, so it sits directly upstream of it.
- Consumes the slave-select stage's `ss`.
- Emits one-cycle send and receive strobes, which the shift-register stage uses to drive MOSI and sample MISO on the correct `sclk` edges for the selected CPOL/CPHA.

---
 rtl/spi_baud_generator_if.sv | 29 ++
 rtl/spi_baud_generator.sv | 71 +++++++
 tb/tb_spi_baud_generator.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_baud_generator_if.sv
// Control and clock-output bundle between the SPI register block, the baud
// generator and the downstream slave-select/shift-register stages.
interface spi_baud_generator_if #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3
);
  logic              mstr;
  logic              spiswai;
  logic [1:0]        spi_mode;
  logic              ss;
  logic              cpol;
  logic              cpha;
  logic [SPPR_W-1:0] sppr;
  logic [SPR_W-1:0]  spr;
  logic              sclk;
  logic              flag_send;
  logic              flag_receive;
  logic [15:0]       BaudRateDivisor;

  modport master (
    output mstr, spiswai, spi_mode, ss, cpol, cpha, sppr, spr,
    input  sclk, flag_send, flag_receive, BaudRateDivisor
  );

  modport slave (
    input  mstr, spiswai, spi_mode, ss, cpol, cpha, sppr, spr,
    output sclk, flag_send, flag_receive, BaudRateDivisor
  );
endinterface

// File: rtl/spi_baud_generator.sv
// SPI master serial-clock generator: divides PCLK down to sclk and marks the
// shift (send) and sample (receive) edges for the selected CPOL/CPHA.
module spi_baud_generator #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int CNT_W  = 12
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  spi_baud_generator_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [15:0] baud_divisor(input logic [SPPR_W-1:0] p,
                                               input logic [SPR_W-1:0]  r);
    logic [15:0] base;
    base = 16'(p) + 16'd1;
    return base << (32'(r) + 32'd1);
  endfunction

  logic [15:0]      divisor;
  logic [15:0]      term;
  logic [CNT_W-1:0] cnt;
  logic             en;
  logic             wrap;
  logic             leading;
  logic             sclk_q;
  logic             send_q;
  logic             recv_q;

  assign divisor              = baud_divisor(bus.sppr, bus.spr);
  assign bus.BaudRateDivisor  = divisor;
  assign bus.sclk             = sclk_q;
  assign bus.flag_send        = send_q;
  assign bus.flag_receive     = recv_q;

  // Run only in master mode with the slave selected, and not while halted in wait mode.
  always_comb begin
    term    = (divisor >> 1) - 16'd1;
    en      = bus.mstr & ~bus.ss &
              ((bus.spi_mode == 2'b00) | ((bus.spi_mode == 2'b01) & ~bus.spiswai));
    // >= rather than == so a divisor shrunk mid-run still wraps immediately.
    wrap    = (16'(cnt) >= term);
    leading = (sclk_q == bus.cpol);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt    <= '0;
      sclk_q <= 1'b0;
      send_q <= 1'b0;
      recv_q <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      sclk_q <= bus.cpol;
      send_q <= 1'b0;
      recv_q <= 1'b0;
    end else if (wrap) begin
      cnt    <= '0;
      sclk_q <= ~sclk_q;
      recv_q <= leading ^ bus.cpha;
      send_q <= ~(leading ^ bus.cpha);
    end else begin
      cnt    <= cnt + CNT_ONE;
      send_q <= 1'b0;
      recv_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_baud_generator.sv
// Bench for spi_baud_generator: directed edge/flag checks plus randomized
// transfers compared every cycle against an edge-count model.
module tb_spi_baud_generator;
  logic PCLK = 1'b0;
  logic PRESETn;

  spi_baud_generator_if #(.SPPR_W(3), .SPR_W(3)) bus ();

  spi_baud_generator #(.SPPR_W(3), .SPR_W(3), .CNT_W(12)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Model: a run's toggles fall on every H-th enabled cycle since enable rose.
  logic m_sclk = 1'b0;
  logic m_send = 1'b0;
  logic m_recv = 1'b0;
  int   m_n    = 0;

  function automatic bit model_en();
    return bus.mstr && !bus.ss &&
           (bus.spi_mode == 2'b00 || (bus.spi_mode == 2'b01 && !bus.spiswai));
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_n = 0; m_sclk = 1'b0; m_send = 1'b0; m_recv = 1'b0;
    end else if (!model_en()) begin
      m_n = 0; m_sclk = bus.cpol; m_send = 1'b0; m_recv = 1'b0;
    end else begin
      int h;
      h   = ((int'(bus.sppr) + 1) << (int'(bus.spr) + 1)) / 2;
      m_n = m_n + 1;
      if (m_n % h == 0) begin
        m_recv = (m_sclk == bus.cpol) ^ bus.cpha;
        m_send = !m_recv;
        m_sclk = !m_sclk;
      end else begin
        m_send = 1'b0; m_recv = 1'b0;
      end
    end
  end

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin
    check("model_sclk", bus.sclk, m_sclk);
    check("model_send", bus.flag_send, m_send);
    check("model_recv", bus.flag_receive, m_recv);
    check("model_div", bus.BaudRateDivisor,
          (int'(bus.sppr) + 1) * (1 << (int'(bus.spr) + 1)));
    check("flags_exclusive", bus.flag_send & bus.flag_receive, 0);
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge PCLK);
      #2;
    end
  endtask

  initial begin
    PRESETn      = 1'b0;
    bus.mstr     = 1'b1;
    bus.spiswai  = 1'b0;
    bus.spi_mode = 2'b00;
    bus.ss       = 1'b1;
    bus.cpol     = 1'b1;
    bus.cpha     = 1'b0;
    bus.sppr     = 3'd1;
    bus.spr      = 3'd1;

    // Reset values and idle level after release
    tick(2);
    check("rst_sclk", bus.sclk, 0);
    check("rst_send", bus.flag_send, 0);
    check("rst_recv", bus.flag_receive, 0);
    check("rst_div", bus.BaudRateDivisor, 8);
    PRESETn = 1'b1;
    tick(1);
    check("idle_cpol1", bus.sclk, 1);

    // Mode 0: rise after 4 cycles, period 8
    bus.cpol = 1'b0; bus.cpha = 1'b0;
    tick(1);
    check("idle_cpol0", bus.sclk, 0);
    bus.ss = 1'b0;
    tick(3);
    check("m0_pre_edge", bus.sclk, 0);
    tick(1);
    check("m0_rise", bus.sclk, 1);
    check("m0_rise_recv", bus.flag_receive, 1);
    check("m0_rise_send", bus.flag_send, 0);
    tick(1);
    check("m0_recv_width", bus.flag_receive, 0);
    tick(2);
    check("m0_hold_high", bus.sclk, 1);
    tick(1);
    check("m0_fall", bus.sclk, 0);
    check("m0_fall_send", bus.flag_send, 1);

    // Mode 3: idle high, send on leading (falling) edge
    bus.ss = 1'b1; bus.cpol = 1'b1; bus.cpha = 1'b1;
    tick(1);
    check("m3_idle", bus.sclk, 1);
    bus.ss = 1'b0;
    tick(4);
    check("m3_lead_fall", bus.sclk, 0);
    check("m3_lead_send", bus.flag_send, 1);
    tick(4);
    check("m3_trail_rise", bus.sclk, 1);
    check("m3_trail_recv", bus.flag_receive, 1);

    // Extremes of the divisor
    bus.ss = 1'b1; bus.sppr = 3'd0; bus.spr = 3'd0;
    tick(1);
    check("div_min", bus.BaudRateDivisor, 2);
    bus.ss = 1'b0;
    tick(1);
    check("d2_edge1", bus.sclk, 0);
    check("d2_send1", bus.flag_send, 1);
    tick(1);
    check("d2_edge2", bus.sclk, 1);
    check("d2_recv2", bus.flag_receive, 1);
    bus.ss = 1'b1; bus.sppr = 3'd7; bus.spr = 3'd7;
    tick(1);
    check("div_max", bus.BaudRateDivisor, 2048);
    bus.ss = 1'b0;
    tick(1023);
    check("dmax_pre_edge", bus.sclk, 1);
    tick(1);
    check("dmax_edge", bus.sclk, 0);

    // Wait-mode halt and ss release mid-transfer
    bus.ss = 1'b1; bus.sppr = 3'd1; bus.spr = 3'd1; bus.cpol = 1'b0; bus.cpha = 1'b0;
    tick(1);
    bus.ss = 1'b0;
    tick(5);
    check("wait_pre_high", bus.sclk, 1);
    bus.spi_mode = 2'b01; bus.spiswai = 1'b1;
    tick(1);
    check("wait_idle", bus.sclk, 0);
    check("wait_flags", bus.flag_send | bus.flag_receive, 0);
    tick(3);
    bus.spi_mode = 2'b00; bus.spiswai = 1'b0;
    tick(3);
    check("wait_restart_pre", bus.sclk, 0);
    tick(1);
    check("wait_restart_edge", bus.sclk, 1);
    bus.ss = 1'b1;
    tick(1);
    check("ss_rise_idle", bus.sclk, 0);

    // Asynchronous reset while sclk is high
    bus.ss = 1'b0;
    tick(4);
    check("arst_pre_high", bus.sclk, 1);
    #1 PRESETn = 1'b0;
    #1;
    check("arst_sclk", bus.sclk, 0);
    check("arst_recv", bus.flag_receive, 0);
    bus.ss = 1'b1;
    tick(1);
    PRESETn = 1'b1;
    tick(1);

    // Slave mode never toggles
    bus.mstr = 1'b0; bus.ss = 1'b0;
    tick(20);
    check("slave_no_toggle", bus.sclk, 0);

    // Randomized transfers; timing/polarity fields change only while deselected
    for (int s = 0; s < 40; s++) begin
      bus.ss       = 1'b1;
      bus.sppr     = 3'($urandom_range(0, 7));
      bus.spr      = 3'($urandom_range(0, 5));
      bus.cpol     = 1'($urandom);
      bus.cpha     = 1'($urandom);
      bus.mstr     = ($urandom_range(0, 7) != 0);
      bus.spi_mode = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      bus.spiswai  = 1'($urandom);
      tick($urandom_range(1, 3));
      bus.ss = 1'b0;
      for (int c = 0; c < int'($urandom_range(30, 400)); c++) begin
        if ($urandom_range(0, 49) == 0) bus.spi_mode = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) bus.spiswai = 1'($urandom);
        if ($urandom_range(0, 99) == 0) bus.mstr = ~bus.mstr;
        if ($urandom_range(0, 149) == 0) bus.ss = ~bus.ss;
        tick(1);
      end
    end

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
